// File: rtl/seq_logic_unit.sv
// Chunk-serial XOR/OR/AND/ANDN unit: WIDTH-bit operands, CHUNK bits per cycle, LSB chunk first.
// Optional SEQ_LOGIC_PARITY_EN adds a Parity output accumulated per chunk.
module seq_logic_unit #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Result,
  output logic             Zero
`ifdef SEQ_LOGIC_PARITY_EN
  ,
  output logic             Parity
`endif
);

  localparam int unsigned N  = WIDTH / CHUNK;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_d;
  logic [CHUNK-1:0] a_chunk_c;
  logic [CHUNK-1:0] b_chunk_c;
  logic [CHUNK-1:0] res_chunk_c;
  int unsigned      shamt_c;

  // Select the current chunk of the latched operands and merge its result in.
  always_comb begin
    shamt_c   = 32'(cnt_q) * CHUNK;
    a_chunk_c = CHUNK'(a_q >> shamt_c);
    b_chunk_c = CHUNK'(b_q >> shamt_c);
    case (op_q)
      2'b00:   res_chunk_c = a_chunk_c ^ b_chunk_c;
      2'b01:   res_chunk_c = a_chunk_c | b_chunk_c;
      2'b10:   res_chunk_c = a_chunk_c & b_chunk_c;
      default: res_chunk_c = a_chunk_c & ~b_chunk_c;
    endcase
    // Result is cleared on acceptance, so OR-ing each chunk in is exact.
    result_d = result_q | (WIDTH'(res_chunk_c) << shamt_c);
  end

`ifdef SEQ_LOGIC_PARITY_EN
  logic parity_q;
  assign Parity = parity_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      result_q <= '0;
`ifdef SEQ_LOGIC_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q      <= A;
            b_q      <= B;
            op_q     <= op;
            result_q <= '0;
            cnt_q    <= '0;
`ifdef SEQ_LOGIC_PARITY_EN
            parity_q <= 1'b0;
`endif
            state_q  <= BUSY;
          end
        end
        BUSY: begin
          result_q <= result_d;
`ifdef SEQ_LOGIC_PARITY_EN
          parity_q <= parity_q ^ (^res_chunk_c);
`endif
          if (cnt_q == CW'(N - 1)) begin
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign Result    = result_q;
  assign Zero      = (result_q == '0);

endmodule

// File: doc/seq_logic_unit.md
Name: seq_logic_unit

Overview:
Parametrised, multi-cycle bitwise logic unit. It is the chunk-serial successor to the 32-bit combinational XOR.
- Performs XOR/OR/AND/ANDN on WIDTH-bit operands, CHUNK bits per cycle, LSB chunk first.
- Uses valid/ready handshakes on both sides.
- Sits beside the ALU logic path for area-reduced RV32I variants and wider-datapath experiments.

Parameters:
WIDTH, 32, operand/result width in bits; must be a multiple of CHUNK.
CHUNK, 8, bits processed per cycle; 1 <= CHUNK <= WIDTH.
(Derived, not a parameter: N = WIDTH/CHUNK, cycles per operation; counter width = max(1, clog2(N)).)

Ports:
clk  input  1  clock; all state updates on rising edge.
rst_n  input  1  synchronous, active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  unit can accept a request (high only in IDLE).
A  input  WIDTH  operand A.
B  input  WIDTH  operand B.
op  input  2  00 XOR, 01 OR, 10 AND, 11 ANDN (A & ~B).
out_valid  output  1  result valid (high only in DONE).
out_ready  input  1  consumer accepts result.
Result  output  WIDTH  result register.
Zero  output  1  Result == 0; meaningful while out_valid.

Behaviour:
- Reset: rst_n sampled low at a rising edge puts the unit in this state:
  - state=IDLE, counter=0, Result=0, Zero=1, out_valid=0, in_ready=1.
  - Latched operands and op are cleared to 0.
- Reset mid-operation (BUSY or DONE) aborts the operation. The pending result is discarded and never presented.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = (state==IDLE).
  - out_valid = (state==DONE).
  - Both are decoded directly from state; no combinational path from in_valid or out_ready.
- IDLE:
  - On in_valid & in_ready: latch A, B, op; clear Result to 0; counter=0; go to BUSY.
  - Otherwise hold. Result keeps its last value.
- BUSY:
  - Each cycle, compute chunk k = counter: Result[k*CHUNK +: CHUNK] = f(op, A_l[k*CHUNK +: CHUNK], B_l[k*CHUNK +: CHUNK]).
  - Increment counter.
  - When counter == N-1: write the final chunk and go to DONE.
  - in_valid and out_ready are ignored in BUSY.
  - Changes on A/B/op after acceptance have no effect (operands are latched).
- DONE:
  - Hold Result and Zero stable.
  - On out_ready: go to IDLE.
  - If out_ready is already high on DONE entry, exactly one cycle of out_valid.
- Latency:
  - Request accepted at edge t; out_valid first high after edge t+N.
  - Earliest next acceptance is edge t+N+2 (one DONE cycle, one IDLE cycle).
  - Throughput is therefore 1 op per N+2 cycles with no backpressure.
- N=1 (CHUNK=WIDTH): BUSY lasts exactly one cycle; the behaviour degenerates to a registered combinational logic op.
- Zero is combinational from Result.
- Chunk indexing never exceeds WIDTH-1; the counter never exceeds N-1.

Optional Feature:
Macro SEQ_LOGIC_PARITY_EN.
- Defined:
  - Extra output port Parity (1 bit) = XOR-reduction of Result; meaningful while out_valid.
  - Parity is accumulated one chunk per BUSY cycle into a register, not recomputed from Result.
  - Parity is cleared to 0 on acceptance and on reset.
- Undefined: Parity port and its register do not exist; all other behaviour is identical.

Test Plan:
1. Reset, then XOR with A=0xFFFF0000, B=0x0F0F0F0F, WIDTH=32, CHUNK=8, out_ready=1.
   -> in_ready drops the cycle after acceptance; out_valid is high after exactly 4 edges; Result=0xF0F00F0F; Zero=0; Parity=0 if enabled.
2. All four ops on A=0xA5A5A5A5, B=0x0FF00FF0.
   -> XOR 0xAA55AA55, OR 0xAFF5AFF5, AND 0x05A005A0, ANDN 0xA005A005.
3. AND with A=0xAAAAAAAA, B=0x55555555, out_ready held low for 5 cycles.
   -> Result=0x00000000 and Zero=1 held stable; in_ready stays 0; a new in_valid is ignored until the handshake completes.
4. Pull rst_n low for one edge during BUSY (after 2 chunks).
   -> next cycle is IDLE: Result=0, out_valid=0, in_ready=1; the following op with A=0x1, B=0x3, XOR returns 0x2.
5. Exhaustive 8-bit sweep: A,B in 0..255 zero-extended, all ops, also with CHUNK=1 and CHUNK=32.
   -> every result equals the golden bitwise expression; error count 0; latency is 32 and 1 edges respectively.
6. Change A/B/op every cycle while BUSY.
   -> Result reflects only the values latched at acceptance.
